// File: rtl/jtag_bb_pkg.sv
// jtag_bb_pkg: command bytes, response bytes and FSM state for the remote-bitbang JTAG engine.
package jtag_bb_pkg;
    localparam logic [7:0] CMD_WR_BASE   = 8'h30;
    localparam logic [7:0] CMD_READ      = 8'h52;
    localparam logic [7:0] CMD_RST_BASE  = 8'h72;
    localparam logic [7:0] CMD_BLINK_ON  = 8'h42;
    localparam logic [7:0] CMD_BLINK_OFF = 8'h62;
    localparam logic [7:0] CMD_QUIT      = 8'h51;
    localparam logic [7:0] RSP_ZERO      = 8'h30;
    localparam logic [7:0] RSP_ONE       = 8'h31;
    typedef enum logic [1:0] {IDLE, HOLD, RD_WAIT, QUIT} jtag_bb_state_e;
endpackage

// File: rtl/jtag_bitbang_engine_if.sv
// jtag_bitbang_engine_if: command byte stream in, ASCII TDO response stream out.
interface jtag_bitbang_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    modport master (output cmd_valid, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data);
    modport slave  (input cmd_valid, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/jtag_bb_rsp_fifo.sv
// jtag_bb_rsp_fifo: synchronous first-word-fall-through FIFO; push while full is accepted only with a pop.
module jtag_bb_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= wdata_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/jtag_bitbang_engine.sv
// jtag_bitbang_engine: OpenOCD remote_bitbang byte decoder driving JTAG pins with programmable TCK hold.
// Define JTAG_BB_TDO_SYNC_EN to pass TDO through a 2-flop synchronizer (needs TCK_DIV >= 3).
module jtag_bitbang_engine
    import jtag_bb_pkg::*;
#(
    parameter int TCK_DIV    = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    jtag_bitbang_engine_if.slave        bus,
    output logic                        jtag_tck_o,
    output logic                        jtag_tms_o,
    output logic                        jtag_tdi_o,
    input  logic                        jtag_tdo_i,
    output logic                        jtag_trst_o,
    output logic                        jtag_srst_o,
    output logic                        blink_o,
    output logic                        quit_o
);
    localparam int CW = $clog2(TCK_DIV + 1);
    localparam int AW = $clog2(RESP_DEPTH);
    jtag_bb_state_e state_q;
    logic [CW-1:0]  cnt_q;
    logic           tck_q, tms_q, tdi_q, trst_q, srst_q, blink_q, quit_q, rbit_q;
    logic           tdo_s, fire, rd, pop, full, empty, can_push, push;
    logic [7:0]     push_data;
    logic [AW:0]    rsp_count_unused;
`ifdef JTAG_BB_TDO_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk)
        sync_q <= rst ? 2'b00 : {sync_q[0], jtag_tdo_i};
    assign tdo_s = sync_q[1];
`else
    assign tdo_s = jtag_tdo_i;
`endif
    assign bus.cmd_ready = state_q == IDLE && !quit_q && !rst;
    assign fire      = bus.cmd_valid && bus.cmd_ready;
    assign rd        = fire && bus.cmd_data == CMD_READ;
    assign pop       = !empty && bus.rsp_ready;
    assign can_push  = !full || pop;
    // RD_WAIT retries the latched bit every cycle; the FIFO drops it until there is room.
    assign push      = rd || state_q == RD_WAIT;
    assign push_data = RSP_ZERO | {7'd0, rd ? tdo_s : rbit_q};
    assign bus.rsp_valid = !empty;
    jtag_bb_rsp_fifo #(.WIDTH(8), .DEPTH(RESP_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (bus.rsp_ready),
        .rdata_o (bus.rsp_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (rsp_count_unused)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            {tck_q, tms_q, tdi_q} <= 3'b010;
            {trst_q, srst_q} <= 2'b00;
            blink_q <= 1'b0;
            quit_q  <= 1'b0;
            rbit_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fire) begin
                    if (bus.cmd_data[7:3] == CMD_WR_BASE[7:3]) begin
                        {tck_q, tms_q, tdi_q} <= bus.cmd_data[2:0];
                        if (TCK_DIV > 1) begin
                            state_q <= HOLD;
                            cnt_q   <= CW'(TCK_DIV - 1);
                        end
                    end else if (rd) begin
                        rbit_q <= tdo_s;
                        if (!can_push) state_q <= RD_WAIT;
                    end else if (bus.cmd_data >= CMD_RST_BASE && bus.cmd_data <= CMD_RST_BASE + 8'd3) begin
                        // 'r','s','t','u' have low bits 10,11,00,01; flipping bit 1 gives {trst,srst}.
                        {trst_q, srst_q} <= bus.cmd_data[1:0] ^ 2'b10;
                    end else if (bus.cmd_data == CMD_BLINK_ON) begin
                        blink_q <= 1'b1;
                    end else if (bus.cmd_data == CMD_BLINK_OFF) begin
                        blink_q <= 1'b0;
                    end else if (bus.cmd_data == CMD_QUIT) begin
                        quit_q  <= 1'b1;
                        state_q <= QUIT;
                    end
                end
                HOLD: begin
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= cnt_q == CW'(1) ? IDLE : HOLD;
                end
                RD_WAIT: state_q <= can_push ? IDLE : RD_WAIT;
                default: ;
            endcase
        end
    end
    assign jtag_tck_o  = tck_q;
    assign jtag_tms_o  = tms_q;
    assign jtag_tdi_o  = tdi_q;
    assign jtag_trst_o = trst_q;
    assign jtag_srst_o = srst_q;
    assign blink_o     = blink_q;
    assign quit_o      = quit_q;
endmodule

// File: tb/tb_jtag_bitbang_engine.sv
// tb_jtag_bitbang_engine: directed vector table plus hand sequences for hold, FIFO back-pressure, quit and reset.
module tb_jtag_bitbang_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tdo = 1'b0;
    logic tck, tms, tdi, trst, srst, blink, quit;
    int   vecs = 0;
    int   errs = 0;
    jtag_bitbang_engine_if bus ();
    jtag_bitbang_engine #(.TCK_DIV(4), .RESP_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .jtag_tck_o  (tck),
        .jtag_tms_o  (tms),
        .jtag_tdi_o  (tdi),
        .jtag_tdo_i  (tdo),
        .jtag_trst_o (trst),
        .jtag_srst_o (srst),
        .blink_o     (blink),
        .quit_o      (quit)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] cmd;
        logic [2:0] pins;
        logic [1:0] rs;
        logic       bl;
    } vec_t;
    vec_t tbl [12];
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            vecs++;
            errs++;
            $display("FAIL send_timeout: cmd_ready stayed 0 for byte %h", b);
        end else begin
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask
    task automatic pop_chk(input logic [7:0] exp);
        chk("rsp_valid", {7'd0, bus.rsp_valid}, 8'd1);
        chk("rsp_data", bus.rsp_data, exp);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        tbl[0]  = '{8'h30, 3'b000, 2'b00, 1'b0};
        tbl[1]  = '{8'h37, 3'b111, 2'b00, 1'b0};
        tbl[2]  = '{8'h75, 3'b111, 2'b11, 1'b0};
        tbl[3]  = '{8'h73, 3'b111, 2'b01, 1'b0};
        tbl[4]  = '{8'h72, 3'b111, 2'b00, 1'b0};
        tbl[5]  = '{8'h74, 3'b111, 2'b10, 1'b0};
        tbl[6]  = '{8'h42, 3'b111, 2'b10, 1'b1};
        tbl[7]  = '{8'h41, 3'b111, 2'b10, 1'b1};
        tbl[8]  = '{8'h62, 3'b111, 2'b10, 1'b0};
        tbl[9]  = '{8'h36, 3'b110, 2'b10, 1'b0};
        tbl[10] = '{8'h00, 3'b110, 2'b10, 1'b0};
        tbl[11] = '{8'h72, 3'b110, 2'b00, 1'b0};
        repeat (2) @(negedge clk);
        chk("rst_pins", {5'd0, tck, tms, tdi}, 8'h02);
        chk("rst_misc", {3'd0, trst, srst, blink, quit, bus.rsp_valid}, 8'h00);
        chk("rst_ready", {7'd0, bus.cmd_ready}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {7'd0, bus.cmd_ready}, 8'd1);
        send(8'h35);
        chk("wr35_pins", {5'd0, tck, tms, tdi}, 8'h05);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_ready_%0d", i), {7'd0, bus.cmd_ready}, {7'd0, i == 3});
            @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].cmd);
            chk($sformatf("tbl%0d_pins", i), {5'd0, tck, tms, tdi}, {5'd0, tbl[i].pins});
            chk($sformatf("tbl%0d_rst", i), {6'd0, trst, srst}, {6'd0, tbl[i].rs});
            chk($sformatf("tbl%0d_blink", i), {7'd0, blink}, {7'd0, tbl[i].bl});
            chk($sformatf("tbl%0d_norsp", i), {7'd0, bus.rsp_valid}, 8'd0);
        end
        tdo = 1'b1;
        send(8'h52);
        chk("rd1_valid", {7'd0, bus.rsp_valid}, 8'd1);
        tdo = 1'b0;
        send(8'h52);
        pop_chk(8'h31);
        pop_chk(8'h30);
        chk("rd_empty", {7'd0, bus.rsp_valid}, 8'd0);
        tdo = 1'b1; send(8'h52);
        tdo = 1'b0; send(8'h52);
        tdo = 1'b1; send(8'h52);
        tdo = 1'b1; send(8'h52);
        tdo = 1'b0; send(8'h52);
        tdo = 1'b1;
        chk("full_wait_ready", {7'd0, bus.cmd_ready}, 8'd0);
        @(negedge clk);
        chk("full_wait_ready2", {7'd0, bus.cmd_ready}, 8'd0);
        pop_chk(8'h31);
        chk("full_release_ready", {7'd0, bus.cmd_ready}, 8'd1);
        pop_chk(8'h30);
        pop_chk(8'h31);
        pop_chk(8'h31);
        pop_chk(8'h30);
        chk("full_drained", {7'd0, bus.rsp_valid}, 8'd0);
        send(8'h51);
        chk("quit_set", {7'd0, quit}, 8'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h31;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("quit_ready_%0d", i), {7'd0, bus.cmd_ready}, 8'd0);
            @(negedge clk);
        end
        chk("quit_pins", {5'd0, tck, tms, tdi}, 8'h06);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("quit_cleared", {7'd0, quit}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("quit_ready_after_rst", {7'd0, bus.cmd_ready}, 8'd1);
        send(8'h52);
        send(8'h37);
        chk("hold_pins", {5'd0, tck, tms, tdi}, 8'h07);
        chk("hold_fifo", {7'd0, bus.rsp_valid}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pins", {5'd0, tck, tms, tdi}, 8'h02);
        chk("midrst_fifo", {7'd0, bus.rsp_valid}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/jtag_bitbang_engine.md
Name: jtag_bitbang_engine

Overview:
- Synthesizable successor to the simulation-only remote-bitbang JTAG driver.
- Consumes a byte-stream of OpenOCD remote_bitbang commands on a valid/ready interface, drives the JTAG/reset pins to the debug module, and returns TDO samples as ASCII bytes on a response stream.
- Generalised with a programmable TCK hold time and a parametrised response FIFO, so a UART or host bridge can front it on FPGA.

Parameters:
- TCK_DIV, 4: clk cycles each pin setting is held before the next command is accepted (>=1).
- RESP_DEPTH, 4: response FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command byte valid
- cmd_ready  out  1  engine accepts command byte this cycle
- cmd_data  in  8  command byte
- rsp_valid  out  1  response byte available
- rsp_ready  in  1  consumer pops response byte
- rsp_data  out  8  response byte, 0x30 or 0x31
- jtag_tck_o  out  1  TCK
- jtag_tms_o  out  1  TMS
- jtag_tdi_o  out  1  TDI
- jtag_tdo_i  in  1  TDO from target
- jtag_trst_o  out  1  TAP reset, 1 = asserted
- jtag_srst_o  out  1  system reset request, 1 = asserted
- blink_o  out  1  activity LED
- quit_o  out  1  sticky; host issued quit

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, trst=0, srst=0, blink=0, quit=0, rsp_valid=0, cmd_ready=0, FIFO empty, state IDLE.
- rst is sampled on clk only. Asserting it mid-operation returns all outputs to reset values on the next edge and discards FIFO contents.
- cmd_ready = (state==IDLE) && !quit && !rst. A byte transfers when cmd_valid && cmd_ready.
- FSM states: IDLE, HOLD, RD_WAIT, QUIT.
- Command decode on transfer:
  - 0x30-0x37 ('0'-'7'): {tck,tms,tdi} <= cmd_data[2:0], registered, visible the next cycle. If TCK_DIV>1, go to HOLD with counter=TCK_DIV-1; otherwise stay IDLE (back-to-back allowed).
  - HOLD: decrement each cycle; return to IDLE when counter reaches 1. cmd_ready is therefore low for exactly TCK_DIV-1 cycles after a pin write.
  - 0x52 ('R'): sample TDO (post-sync value) in the transfer cycle. Push 0x30+tdo if FIFO not full, or if full with a pop in the same cycle. Otherwise latch the bit and go to RD_WAIT; push when space frees, then return to IDLE.
  - 0x72-0x75 ('r','s','t','u'): {trst,srst} <= {0,0}/{0,1}/{1,0}/{1,1}. Stay IDLE, no hold.
  - 0x42 ('B'): blink=1. 0x62 ('b'): blink=0.
  - 0x51 ('Q'): quit=1, go to QUIT. cmd_ready stays 0 until rst; pins hold their last values; FIFO still drains.
  - Any other byte: consumed, no effect, no response.
- Response FIFO:
  - rsp_valid = !empty. rsp_data = head entry, first-word fall-through.
  - Pop when rsp_valid && rsp_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Pointers are log2(RESP_DEPTH) bits and wrap naturally. Count is log2(RESP_DEPTH)+1 bits.
- Response ordering equals 'R' acceptance order.

Optional Feature:
- Macro: JTAG_BB_TDO_SYNC_EN.
- Defined: jtag_tdo_i passes through a 2-flop synchronizer (reset 0). 'R' samples the synchronizer output, so TDO latency is 2 cycles. TCK_DIV must be >=3 so TDO settles after a TCK edge.
- Undefined: jtag_tdo_i is sampled directly in the 'R' transfer cycle.

Decomposition:
- Package jtag_bb_pkg holds:
  - command byte localparams (CMD_WR_BASE=8'h30, CMD_READ=8'h52, CMD_RST_BASE=8'h72, CMD_BLINK_ON=8'h42, CMD_BLINK_OFF=8'h62, CMD_QUIT=8'h51);
  - response constants RSP_ZERO=8'h30, RSP_ONE=8'h31;
  - FSM enum jtag_bb_state_e {IDLE, HOLD, RD_WAIT, QUIT}.
- One sub-module: jtag_bb_rsp_fifo (synchronous FWFT FIFO, parametrised WIDTH/DEPTH, full/empty/count outputs).

Test Plan:
- After rst, TCK_DIV=4, send 0x35 -> next cycle tck=1, tms=0, tdi=1; cmd_ready low 3 cycles, high on 4th.
- tdo=1, send 0x52; then tdo=0, send 0x52 -> rsp stream 0x31, 0x30 in order; rsp_valid 1 cycle after acceptance (no-sync build).
- rsp_ready=0, RESP_DEPTH=4, send five 0x52 -> 4 in FIFO, fifth in RD_WAIT with cmd_ready=0; one pop -> fifth pushed next cycle; all five drained in order.
- Send 0x75, 0x73, 0x72 -> {trst,srst}={1,1}, then {0,1}, then {0,0}; 0x41 consumed with no output change and no response.
- Send 0x51 -> quit_o=1, cmd_ready stuck 0 while cmd_valid=1; assert rst -> quit_o=0, cmd_ready=1 one cycle after rst deasserts.
- Send 0x37, then assert rst during HOLD -> next edge tck=0, tms=1, tdi=0, FIFO empty.
